// File: rtl/npc_pkg.sv
// Shared definitions for the memory-access stage.
//   MEM_OP_*  : memory operation carried with each instruction (none/load/store)
//   SIZE_*    : access width (byte/half/word)
//   ST_*      : memory-stage FSM state encodings
//   is_misaligned : natural-alignment test for a given access width and address LSBs
package npc_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The unused size encoding is treated as a word access, matching mem_align.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    if (size == SIZE_BYTE) begin
      mis = 1'b0;
    end else if (size == SIZE_HALF) begin
      mis = addr_lo[0];
    end else begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane helper for the memory stage.
//   addr_lo    in  : address bits [1:0] of the access
//   size       in  : SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   is_signed  in  : sign-extend (1) or zero-extend (0) narrow loads
//   store_data in  : store source register value
//   rdata      in  : whole-word read data from the bus
//   wstrb      out : byte-lane enables for a store
//   wdata      out : store data replicated across all lanes of its width
//   load_data  out : load data shifted down to bit 0 and extended
module mem_align
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_signed,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  // Narrow data is replicated so the addressed lane always holds it;
  // the strobe picks which lane(s) the bus actually writes.
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    wstrb     = 4'hF;
    wdata     = store_data;
    load_data = shifted;
    case (size)
      SIZE_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wstrb     = 4'hF;
        wdata     = store_data;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage downstream of the ALU.
// Takes the ALU result as a load/store address (or passes it through for
// non-memory ops), runs one valid/ready bus request per memory op, waits for
// the response, and presents one registered result per instruction to writeback.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready + in_*      : instruction from EX
//   mem_req_* (valid/ready)       : bus request (word-aligned address, lane strobes)
//   mem_resp_valid/mem_resp_rdata : bus response (read data or write ack)
//   out_valid/out_ready + out_*   : registered result slot to writeback
module mem_stage
  import npc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_y,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [1:0]        in_mem_op,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_reg_we,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_reg_we,
  output logic              out_misalign
);

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   store_data_q, store_data_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              is_store_q, is_store_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic              reg_we_q, reg_we_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [RIDX_W-1:0] out_rd_q, out_rd_d;
  logic              out_reg_we_q, out_reg_we_d;
  logic              out_misalign_q, out_misalign_d;

  logic              accept;
  logic              in_misalign;
  logic              req_active;
  logic [3:0]        align_wstrb;
  logic [XLEN-1:0]   align_wdata;
  logic [XLEN-1:0]   align_load;

  // Lane steering works from the latched access so the request stays stable
  // while the bus stalls and the load extract uses the issuing address.
  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .store_data (store_data_q),
    .rdata      (mem_resp_rdata),
    .wstrb      (align_wstrb),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  // New work is only taken in IDLE, and only when the result slot is empty or
  // draining this cycle, so a memory op never finds the slot occupied at RESP.
  assign in_ready    = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign accept      = in_valid & in_ready;
  assign in_misalign = (in_mem_op != MEM_OP_NONE) & is_misaligned(in_size, in_alu_y[1:0]);

  // Next-state logic: the result slot drains on transfer and is refilled by
  // a pass-through op, a misaligned (unissued) access, or a bus response.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    store_data_d   = store_data_q;
    size_d         = size_q;
    signed_d       = signed_q;
    is_store_d     = is_store_q;
    rd_d           = rd_q;
    reg_we_d       = reg_we_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_rd_d       = out_rd_q;
    out_reg_we_d   = out_reg_we_q;
    out_misalign_d = out_misalign_q;

    if (out_valid_q && out_ready) begin
      out_valid_d    = 1'b0;
      out_data_d     = '0;
      out_rd_d       = '0;
      out_reg_we_d   = 1'b0;
      out_misalign_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_mem_op == MEM_OP_NONE) begin
            out_valid_d    = 1'b1;
            out_data_d     = in_alu_y;
            out_rd_d       = in_rd;
            out_reg_we_d   = in_reg_we & (in_rd != '0);
            out_misalign_d = 1'b0;
          end else if (in_misalign) begin
            out_valid_d    = 1'b1;
            out_data_d     = in_alu_y;
            out_rd_d       = in_rd;
            out_reg_we_d   = 1'b0;
            out_misalign_d = 1'b1;
          end else begin
            addr_d       = in_alu_y;
            store_data_d = in_store_data;
            size_d       = in_size;
            signed_d     = in_signed;
            is_store_d   = (in_mem_op == MEM_OP_STORE);
            rd_d         = in_rd;
            reg_we_d     = in_reg_we;
            state_d      = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          out_valid_d    = 1'b1;
          out_data_d     = is_store_q ? '0 : align_load;
          out_rd_d       = rd_q;
          out_reg_we_d   = reg_we_q & (rd_q != '0) & ~is_store_q;
          out_misalign_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and the result slot clear immediately on reset, even mid-access,
  // which also makes any late response from the bus land in IDLE and be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      store_data_q   <= '0;
      size_q         <= SIZE_BYTE;
      signed_q       <= 1'b0;
      is_store_q     <= 1'b0;
      rd_q           <= '0;
      reg_we_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_rd_q       <= '0;
      out_reg_we_q   <= 1'b0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      store_data_q   <= store_data_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      is_store_q     <= is_store_d;
      rd_q           <= rd_d;
      reg_we_q       <= reg_we_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_rd_q       <= out_rd_d;
      out_reg_we_q   <= out_reg_we_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  // Bus outputs are driven only while a request is pending and are zero otherwise.
  assign req_active    = (state_q == ST_REQ);
  assign mem_req_valid = req_active;
  assign mem_req_we    = req_active & is_store_q;
  assign mem_req_addr  = req_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_req_wstrb = mem_req_we ? align_wstrb : 4'b0000;
  assign mem_req_wdata = mem_req_we ? align_wdata : '0;

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_rd       = out_rd_q;
  assign out_reg_we   = out_reg_we_q;
  assign out_misalign = out_misalign_q;

endmodule
